// File: rtl/bpu_pht.sv
// bpu_pht: pattern-history-table branch predictor with 2-bit saturating
// counters, selectable bimodal/gshare indexing and commit-only history.
// The index that made a prediction travels with the instruction through
// D, E and M, and that same index is the one trained at commit.
module bpu_pht #(
  parameter int         IDX_W    = 8,
  parameter int         GHR_W    = 8,
  parameter int         MODE     = 1,
  parameter logic [1:0] CNT_INIT = 2'b01
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      pcF,
  input  logic             stallD,
  input  logic             stallE,
  input  logic             stallM,
  input  logic             flushD,
  input  logic             flushE,
  input  logic             flushM,
  input  logic             branchD,
  input  logic             actual_takeM,
  output logic             pred_takeD,
  output logic             pred_takeM,
  output logic             mispredictM,
  output logic [GHR_W-1:0] ghr,
  output logic [31:0]      n_branch,
  output logic [31:0]      n_miss
);

  localparam int DEPTH = 1 << IDX_W;

  logic [1:0]       pht [DEPTH];
  logic [IDX_W-1:0] pcIdx;
  logic [IDX_W-1:0] idxF;
  logic [IDX_W-1:0] idxD;
  logic [IDX_W-1:0] idxE;
  logic [IDX_W-1:0] idxM;
  logic             predE;
  logic             predM;
  logic             brE;
  logic             brM;
  logic [GHR_W-1:0] ghrQ;
  logic [GHR_W-1:0] ghrNext;
  logic [31:0]      nBranchQ;
  logic [31:0]      nMissQ;
  logic [1:0]       cntCur;
  logic [1:0]       cntNext;
  logic             commit;
  logic             unusedPc;

  // Word-aligned PC bits select the entry; the rest of the PC is ignored.
  assign pcIdx    = pcF[IDX_W+1:2];
  assign unusedPc = ^{pcF[31:IDX_W+2], pcF[1:0]};

  generate
    if (MODE == 0) begin : gBimodal
      assign idxF = pcIdx;
    end else begin : gGshare
      assign idxF = pcIdx ^ IDX_W'(ghrQ);
    end
  endgenerate

  generate
    if (GHR_W == 1) begin : gHist1
      assign ghrNext = actual_takeM;
    end else begin : gHistN
      assign ghrNext = {ghrQ[GHR_W-2:0], actual_takeM};
    end
  endgenerate

  assign pred_takeD  = branchD & pht[idxD][1];
  assign pred_takeM  = predM;
  assign mispredictM = brM & (predM != actual_takeM);
  assign commit      = brM & ~stallM & ~flushM;
  assign ghr         = ghrQ;
  assign n_branch    = nBranchQ;
  assign n_miss      = nMissQ;
  assign cntCur      = pht[idxM];

  // Saturating step of the counter being trained.
  always_comb begin
    cntNext = cntCur;
    if (actual_takeM) begin
      if (cntCur != 2'b11) cntNext = cntCur + 2'b01;
    end else begin
      if (cntCur != 2'b00) cntNext = cntCur - 2'b01;
    end
  end

  // F->D register: index sampled as the instruction enters Decode.
  always_ff @(posedge clk) begin
    if (rst || flushD) idxD <= '0;
    else if (!stallD)  idxD <= idxF;
  end

  // D->E register: index, prediction and branch flag.
  always_ff @(posedge clk) begin
    if (rst || flushE) begin
      idxE  <= '0;
      predE <= 1'b0;
      brE   <= 1'b0;
    end else if (!stallE) begin
      idxE  <= idxD;
      predE <= pred_takeD;
      brE   <= branchD;
    end
  end

  // E->M register: the same triple one stage later.
  always_ff @(posedge clk) begin
    if (rst || flushM) begin
      idxM  <= '0;
      predM <= 1'b0;
      brM   <= 1'b0;
    end else if (!stallM) begin
      idxM  <= idxE;
      predM <= predE;
      brM   <= brE;
    end
  end

  // Table training; no bypass, so a same-cycle D read sees the old value.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) pht[i] <= CNT_INIT;
    end else if (commit) begin
      pht[idxM] <= cntNext;
    end
  end

  // Committed history and saturating statistics.
  always_ff @(posedge clk) begin
    if (rst) begin
      ghrQ     <= '0;
      nBranchQ <= '0;
      nMissQ   <= '0;
    end else if (commit) begin
      ghrQ <= ghrNext;
      if (nBranchQ != 32'hFFFF_FFFF) nBranchQ <= nBranchQ + 32'd1;
      if (mispredictM && (nMissQ != 32'hFFFF_FFFF)) nMissQ <= nMissQ + 32'd1;
    end
  end

endmodule

// File: tb/tb_bpu_pht.sv
module tb_bpu_pht;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] pcF = '0;
  logic        stallD = 0, stallE = 0, stallM = 0;
  logic        flushD = 0, flushE = 0, flushM = 0;
  logic        branchD = 0, actual_takeM = 0;

  logic        predD0, predM0, misp0;
  logic [7:0]  ghr0;
  logic [31:0] nb0, nm0;
  logic        predD1, predM1, misp1;
  logic [1:0]  ghr1;
  logic [31:0] nb1, nm1;

  int passCnt = 0;
  int totalCnt = 0;

  always #5 clk = ~clk;

  bpu_pht #(.IDX_W(8), .GHR_W(8), .MODE(0), .CNT_INIT(2'b01)) u0 (
    .clk(clk), .rst(rst), .pcF(pcF),
    .stallD(stallD), .stallE(stallE), .stallM(stallM),
    .flushD(flushD), .flushE(flushE), .flushM(flushM),
    .branchD(branchD), .actual_takeM(actual_takeM),
    .pred_takeD(predD0), .pred_takeM(predM0), .mispredictM(misp0),
    .ghr(ghr0), .n_branch(nb0), .n_miss(nm0));

  bpu_pht #(.IDX_W(4), .GHR_W(2), .MODE(1), .CNT_INIT(2'b01)) u1 (
    .clk(clk), .rst(rst), .pcF(pcF),
    .stallD(stallD), .stallE(stallE), .stallM(stallM),
    .flushD(flushD), .flushE(flushE), .flushM(flushM),
    .branchD(branchD), .actual_takeM(actual_takeM),
    .pred_takeD(predD1), .pred_takeM(predM1), .mispredictM(misp1),
    .ghr(ghr1), .n_branch(nb1), .n_miss(nm1));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    totalCnt++;
    if (act === exp) passCnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // ---------------- reference model (instruction-level view) ----------------
  int     depthK[2]  = '{256, 16};
  int     ghrMod[2]  = '{256, 4};
  int     modeK[2]   = '{0, 1};
  int     mPht[2][256];
  int     mGhr[2];
  longint mNb[2], mNm[2];
  int     mDIdx[2], mEIdx[2], mMIdx[2];
  bit     mEPred[2], mEBr[2], mMPred[2], mMBr[2];
  localparam longint CMAX = 64'h0000_0000_FFFF_FFFF;

  function automatic int idxOf(input int k, input logic [31:0] pc);
    int p;
    p = int'(pc >> 2) % depthK[k];
    return (modeK[k] != 0) ? (p ^ mGhr[k]) : p;
  endfunction

  task automatic modelReset();
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 256; i++) mPht[k][i] = 1;
      mGhr[k] = 0; mNb[k] = 0; mNm[k] = 0;
      mDIdx[k] = 0; mEIdx[k] = 0; mMIdx[k] = 0;
      mEPred[k] = 0; mEBr[k] = 0; mMPred[k] = 0; mMBr[k] = 0;
    end
  endtask

  // Applied once per rising edge with the inputs present at that edge.
  task automatic modelStep();
    for (int k = 0; k < 2; k++) begin
      int fIdx;
      bit pD, miss, cm;
      fIdx = idxOf(k, pcF);
      pD   = branchD && (mPht[k][mDIdx[k]] >= 2);
      miss = mMBr[k] && (mMPred[k] != actual_takeM);
      cm   = mMBr[k] && !stallM && !flushM;
      if (rst) continue;
      if (cm) begin
        if (actual_takeM) mPht[k][mMIdx[k]] = (mPht[k][mMIdx[k]] < 3) ? mPht[k][mMIdx[k]] + 1 : 3;
        else              mPht[k][mMIdx[k]] = (mPht[k][mMIdx[k]] > 0) ? mPht[k][mMIdx[k]] - 1 : 0;
        mGhr[k] = (mGhr[k] * 2 + int'(actual_takeM)) % ghrMod[k];
        if (mNb[k] < CMAX) mNb[k]++;
        if (miss && mNm[k] < CMAX) mNm[k]++;
      end
      if (flushM) begin mMIdx[k] = 0; mMPred[k] = 0; mMBr[k] = 0; end
      else if (!stallM) begin mMIdx[k] = mEIdx[k]; mMPred[k] = mEPred[k]; mMBr[k] = mEBr[k]; end
      if (flushE) begin mEIdx[k] = 0; mEPred[k] = 0; mEBr[k] = 0; end
      else if (!stallE) begin mEIdx[k] = mDIdx[k]; mEPred[k] = pD; mEBr[k] = branchD; end
      if (flushD) mDIdx[k] = 0;
      else if (!stallD) mDIdx[k] = fIdx;
    end
    if (rst) modelReset();
  endtask

  task automatic compareAll();
    chk("rnd pred_takeD u0", predD0, branchD && (mPht[0][mDIdx[0]] >= 2));
    chk("rnd pred_takeM u0", predM0, mMPred[0]);
    chk("rnd mispredictM u0", misp0, mMBr[0] && (mMPred[0] != actual_takeM));
    chk("rnd ghr u0", ghr0, mGhr[0]);
    chk("rnd n_branch u0", nb0, mNb[0][31:0]);
    chk("rnd n_miss u0", nm0, mNm[0][31:0]);
    chk("rnd pred_takeD u1", predD1, branchD && (mPht[1][mDIdx[1]] >= 2));
    chk("rnd pred_takeM u1", predM1, mMPred[1]);
    chk("rnd mispredictM u1", misp1, mMBr[1] && (mMPred[1] != actual_takeM));
    chk("rnd ghr u1", ghr1, mGhr[1]);
    chk("rnd n_branch u1", nb1, mNb[1][31:0]);
    chk("rnd n_miss u1", nm1, mNm[1][31:0]);
  endtask

  // ---------------- directed helpers ----------------
  task automatic doReset();
    @(negedge clk);
    rst = 1; branchD = 0; actual_takeM = 0;
    stallD = 0; stallE = 0; stallM = 0; flushD = 0; flushE = 0; flushM = 0;
    @(negedge clk);
    rst = 0;
  endtask

  task automatic checkReset();
    int bad0, bad1;
    branchD = 1; pcF = 32'h0000_0abc;
    #1;
    chk("reset pred_takeD u0", predD0, 1'b0);
    chk("reset pred_takeD u1", predD1, 1'b0);
    chk("reset pred_takeM", {predM0, predM1}, 2'b00);
    chk("reset mispredictM", {misp0, misp1}, 2'b00);
    chk("reset ghr u0", ghr0, 8'h00);
    chk("reset ghr u1", ghr1, 2'b00);
    chk("reset n_branch", nb0 | nb1, 32'd0);
    chk("reset n_miss", nm0 | nm1, 32'd0);
    bad0 = 0; bad1 = 0;
    for (int i = 0; i < 256; i++) if (u0.pht[i] !== 2'b01) bad0++;
    for (int i = 0; i < 16; i++)  if (u1.pht[i] !== 2'b01) bad1++;
    chk("reset table u0 bad entries", bad0, 0);
    chk("reset table u1 bad entries", bad1, 0);
    branchD = 0;
  endtask

  // One isolated branch flowing F->D->E->M->commit.
  task automatic issueBranch(input logic [31:0] pc, input logic taken,
                             output logic p0, output logic p1,
                             output logic ms0, output logic ms1);
    @(negedge clk); pcF = pc; branchD = 0; actual_takeM = 0;
    @(negedge clk); branchD = 1; #1; p0 = predD0; p1 = predD1;
    @(negedge clk); branchD = 0;
    @(negedge clk); actual_takeM = taken; #1; ms0 = misp0; ms1 = misp1;
    @(negedge clk); actual_takeM = 0;
  endtask

  typedef struct {
    logic [31:0] pc;
    logic        taken;
    logic        expPred;
    logic        expMiss;
    logic [1:0]  expCnt;
  } satVec_t;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    satVec_t sat[8];
    logic p0, p1, ms0, ms1;

    sat[0] = '{32'h100, 1'b1, 1'b0, 1'b1, 2'd2};
    sat[1] = '{32'h100, 1'b1, 1'b1, 1'b0, 2'd3};
    sat[2] = '{32'h100, 1'b1, 1'b1, 1'b0, 2'd3};
    sat[3] = '{32'h100, 1'b1, 1'b1, 1'b0, 2'd3};
    sat[4] = '{32'h100, 1'b0, 1'b1, 1'b1, 2'd2};
    sat[5] = '{32'h100, 1'b0, 1'b1, 1'b1, 2'd1};
    sat[6] = '{32'h100, 1'b0, 1'b0, 1'b0, 2'd0};
    sat[7] = '{32'h100, 1'b0, 1'b0, 1'b0, 2'd0};

    doReset();
    checkReset();

    // Saturation in both directions on one bimodal entry (idx 0x40).
    for (int i = 0; i < 8; i++) begin
      issueBranch(sat[i].pc, sat[i].taken, p0, p1, ms0, ms1);
      chk($sformatf("sat[%0d] pred_takeD", i), p0, sat[i].expPred);
      chk($sformatf("sat[%0d] mispredictM", i), ms0, sat[i].expMiss);
      chk($sformatf("sat[%0d] counter", i), u0.pht[8'h40], sat[i].expCnt);
    end
    chk("sat n_branch", nb0, 32'd8);
    chk("sat n_miss", nm0, 32'd3);
    chk("sat ghr", ghr0, 8'hF0);

    // Gshare: history T,T moves PC 0x0 to idx 3 and PC 0xC to idx 0.
    doReset();
    issueBranch(32'h10, 1'b1, p0, p1, ms0, ms1);
    issueBranch(32'h10, 1'b1, p0, p1, ms0, ms1);
    chk("gshare ghr after T,T", ghr1, 2'b11);
    chk("gshare idx4 trained", u1.pht[4], 2'd2);
    chk("gshare idx5 trained", u1.pht[5], 2'd2);
    issueBranch(32'h0, 1'b1, p0, p1, ms0, ms1);
    chk("gshare pc0 trains idx3", u1.pht[3], 2'd2);
    chk("gshare idx0 untouched", u1.pht[0], 2'd1);
    issueBranch(32'hC, 1'b1, p0, p1, ms0, ms1);
    chk("gshare pcC pred", p1, 1'b0);
    chk("gshare pcC miss", ms1, 1'b1);
    chk("gshare pcC trains idx0", u1.pht[0], 2'd2);
    chk("gshare idx3 unchanged", u1.pht[3], 2'd2);

    // Stall holds a commit for three cycles; trained exactly once.
    doReset();
    @(negedge clk); pcF = 32'h200; branchD = 0; actual_takeM = 0;
    @(negedge clk); branchD = 1;
    @(negedge clk); branchD = 0;
    @(negedge clk); actual_takeM = 1; stallM = 1;
    repeat (3) @(negedge clk);
    chk("stall counter held", u0.pht[8'h80], 2'd1);
    chk("stall n_branch held", nb0, 32'd0);
    chk("stall mispredictM ungated", misp0, 1'b1);
    stallM = 0;
    @(negedge clk);
    chk("stall release counter", u0.pht[8'h80], 2'd2);
    chk("stall release n_branch", nb0, 32'd1);
    chk("stall release n_miss", nm0, 32'd1);
    @(negedge clk);
    chk("stall single train", u0.pht[8'h80], 2'd2);
    chk("stall single count", nb0, 32'd1);
    actual_takeM = 0;

    // Flush in M: no training, no count, mispredict still visible.
    @(negedge clk); pcF = 32'h200; branchD = 0;
    @(negedge clk); branchD = 1; #1;
    chk("flush pred_takeD", predD0, 1'b1);
    @(negedge clk); branchD = 0;
    @(negedge clk); actual_takeM = 0; flushM = 1; #1;
    chk("flush pred_takeM", predM0, 1'b1);
    chk("flush mispredictM", misp0, 1'b1);
    @(negedge clk); flushM = 0;
    chk("flush counter", u0.pht[8'h80], 2'd2);
    chk("flush n_branch", nb0, 32'd1);
    chk("flush n_miss", nm0, 32'd1);
    chk("flush ghr", ghr0, 8'h01);
    chk("flush clears predM", predM0, 1'b0);

    // Same-cycle commit and D read at idx 0x41: old value, then new.
    @(negedge clk); pcF = 32'h104; branchD = 0; actual_takeM = 0;
    @(negedge clk); branchD = 1; #1;
    chk("rw first pred", predD0, 1'b0);
    @(negedge clk); branchD = 0;
    @(negedge clk); branchD = 1; actual_takeM = 1; #1;
    chk("rw same-cycle pred old", predD0, 1'b0);
    chk("rw same-cycle miss", misp0, 1'b1);
    @(negedge clk); branchD = 1; actual_takeM = 0; #1;
    chk("rw next-cycle pred new", predD0, 1'b1);
    chk("rw counter", u0.pht[8'h41], 2'd2);
    @(negedge clk); branchD = 0;
    repeat (3) @(negedge clk);

    // n_miss saturation.
    doReset();
    @(negedge clk);
    force u0.nMissQ = 32'hFFFF_FFFF;
    #1;
    release u0.nMissQ;
    issueBranch(32'h500, 1'b1, p0, p1, ms0, ms1);
    chk("nmiss sat mispredict", ms0, 1'b1);
    chk("nmiss saturated", nm0, 32'hFFFF_FFFF);
    chk("nmiss sat n_branch", nb0, 32'd1);

    // Randomized run against the reference model.
    doReset();
    checkReset();
    modelReset();
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      rst          = ($urandom_range(0, 99) == 0);
      pcF          = ($urandom & 32'hFFFF_F000) | (32'($urandom_range(0, 15)) << 2);
      stallD       = ($urandom_range(0, 5) == 0);
      stallE       = ($urandom_range(0, 5) == 0);
      stallM       = ($urandom_range(0, 5) == 0);
      flushD       = ($urandom_range(0, 9) == 0);
      flushE       = ($urandom_range(0, 9) == 0);
      flushM       = ($urandom_range(0, 9) == 0);
      branchD      = 1'($urandom_range(0, 1));
      actual_takeM = 1'($urandom_range(0, 1));
      #1;
      compareAll();
      @(posedge clk);
      modelStep();
    end
    begin
      int bad0, bad1;
      @(negedge clk);
      bad0 = 0; bad1 = 0;
      for (int i = 0; i < 256; i++) if (int'(u0.pht[i]) != mPht[0][i]) bad0++;
      for (int i = 0; i < 16; i++)  if (int'(u1.pht[i]) != mPht[1][i]) bad1++;
      chk("final table u0 bad entries", bad0, 0);
      chk("final table u1 bad entries", bad1, 0);
    end

    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule
